gpio_axi_lite_slave: RTL and testbench

//  AXI4-Lite responder (slave) for the GPIO peripheral; the other end of the master VIP used in the GPIO bench.

---
 rtl/gpio_pkg.sv | 17 +
 rtl/gpio_sync_edge.sv | 27 ++
 rtl/gpio_axi_lite_slave.sv | 150 +++++++++++++++
 tb/tb_gpio_axi_lite_slave.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// gpio_pkg: register map, response codes and address decode helpers for the GPIO AXI-Lite slave
package gpio_pkg;
   localparam int GPIO_WIDTH_DEF = 32;
   localparam logic [4:0] REG_DATA_OUT   = 5'h00;
   localparam logic [4:0] REG_DIR        = 5'h04;
   localparam logic [4:0] REG_IRQ_EN     = 5'h08;
   localparam logic [4:0] REG_SCRATCH    = 5'h0C;
   localparam logic [4:0] REG_GPIO_IN    = 5'h10;
   localparam logic [4:0] REG_IRQ_STATUS = 5'h14;
   typedef enum logic [1:0] {OKAY = 2'b00, SLVERR = 2'b10} resp_t;
   function automatic logic [4:0] word_addr(input logic [4:0] addr);
      return addr & 5'h1C;
   endfunction
   function automatic logic is_mapped(input logic [4:0] addr);
      return word_addr(addr) <= REG_IRQ_STATUS;
   endfunction
endpackage

// File: rtl/gpio_sync_edge.sv
// gpio_sync_edge: 2-flop synchronizer for asynchronous pins plus one history flop for rising-edge detection
module gpio_sync_edge
   import gpio_pkg::*;
#(
   parameter int W = GPIO_WIDTH_DEF
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic [W-1:0] i_pin,
   output logic [W-1:0] o_sync,
   output logic [W-1:0] o_rise
);
   logic [W-1:0] r_meta, r_sync, r_prev;
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= '0;
         r_sync <= '0;
         r_prev <= '0;
      end else begin
         r_meta <= i_pin;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end
   assign o_sync = r_sync;
   assign o_rise = r_sync & ~r_prev;
endmodule

// File: rtl/gpio_axi_lite_slave.sv
// gpio_axi_lite_slave: AXI4-Lite slave with GPIO register file, synchronized inputs and
// a level interrupt on masked rising edges.
module gpio_axi_lite_slave
   import gpio_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 5,
   parameter int GPIO_WIDTH         = GPIO_WIDTH_DEF
) (
   input  logic                            S_AXI_ACLK,
   input  logic                            S_AXI_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   input  logic [GPIO_WIDTH-1:0]           gpio_i,
   output logic [GPIO_WIDTH-1:0]           gpio_o,
   output logic [GPIO_WIDTH-1:0]           gpio_t,
   output logic                            irq
);
   logic                  r_awready, r_wready, r_arready;
   logic                  r_aw_full, r_w_full, r_bvalid, r_rvalid, r_irq;
   logic [4:0]            r_aw_addr;
   logic [31:0]           r_wdata, r_rdata;
   logic [3:0]            r_wstrb;
   resp_t                 r_bresp, r_rresp;
   logic [GPIO_WIDTH-1:0] r_data_out, r_dir, r_irq_en, r_scratch, r_irq_status;
   logic                  w_aw_hs, w_w_hs, w_ar_hs, w_commit;
   logic                  w_we_data, w_we_dir, w_we_en, w_we_scratch;
   logic [4:0]            w_aw_word, w_ar_word;
   logic [31:0]           w_bmask, w_rdata;
   logic [GPIO_WIDTH-1:0] w_m, w_wd, w_clr, w_sync, w_rise;
   logic                  w_unused;
   assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT};
   gpio_sync_edge #(.W(GPIO_WIDTH)) u_sync (
      .i_clk   (S_AXI_ACLK),
      .i_rst_n (S_AXI_ARESETN),
      .i_pin   (gpio_i),
      .o_sync  (w_sync),
      .o_rise  (w_rise)
   );
   assign w_aw_hs  = S_AXI_AWVALID & r_awready;
   assign w_w_hs   = S_AXI_WVALID & r_wready;
   assign w_ar_hs  = S_AXI_ARVALID & r_arready;
   // a commit waits for both halves and for the previous response to drain
   assign w_commit = r_aw_full & r_w_full & ~r_bvalid;
   assign w_aw_word = word_addr(r_aw_addr);
   assign w_ar_word = word_addr(5'(S_AXI_ARADDR));
   assign w_bmask   = {{8{r_wstrb[3]}}, {8{r_wstrb[2]}}, {8{r_wstrb[1]}}, {8{r_wstrb[0]}}};
   assign w_m       = w_bmask[GPIO_WIDTH-1:0];
   assign w_wd      = r_wdata[GPIO_WIDTH-1:0];
   assign w_we_data    = w_commit & (w_aw_word == REG_DATA_OUT);
   assign w_we_dir     = w_commit & (w_aw_word == REG_DIR);
   assign w_we_en      = w_commit & (w_aw_word == REG_IRQ_EN);
   assign w_we_scratch = w_commit & (w_aw_word == REG_SCRATCH);
   assign w_clr = (w_commit && w_aw_word == REG_IRQ_STATUS) ? (w_wd & w_m) : '0;
   assign w_rdata = (w_ar_word == REG_DATA_OUT)   ? 32'(r_data_out)   :
                    (w_ar_word == REG_DIR)        ? 32'(r_dir)        :
                    (w_ar_word == REG_IRQ_EN)     ? 32'(r_irq_en)     :
                    (w_ar_word == REG_SCRATCH)    ? 32'(r_scratch)    :
                    (w_ar_word == REG_GPIO_IN)    ? 32'(w_sync)       :
                    (w_ar_word == REG_IRQ_STATUS) ? 32'(r_irq_status) : '0;
   function automatic logic [GPIO_WIDTH-1:0] merge(input logic [GPIO_WIDTH-1:0] old);
      return (old & ~w_m) | (w_wd & w_m);
   endfunction
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_arready <= 1'b0;
         r_aw_full <= 1'b0;
         r_w_full  <= 1'b0;
         r_aw_addr <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_bvalid  <= 1'b0;
         r_bresp   <= OKAY;
         r_rvalid  <= 1'b0;
         r_rresp   <= OKAY;
         r_rdata   <= '0;
      end else begin
         r_awready <= w_commit | (~r_aw_full & ~w_aw_hs);
         r_wready  <= w_commit | (~r_w_full & ~w_w_hs);
         r_arready <= ~w_ar_hs & (~r_rvalid | S_AXI_RREADY);
         if (w_aw_hs) begin
            r_aw_full <= 1'b1;
            r_aw_addr <= 5'(S_AXI_AWADDR);
         end else if (w_commit) r_aw_full <= 1'b0;
         if (w_w_hs) begin
            r_w_full <= 1'b1;
            r_wdata  <= 32'(S_AXI_WDATA);
            r_wstrb  <= 4'(S_AXI_WSTRB);
         end else if (w_commit) r_w_full <= 1'b0;
         if (w_commit) begin
            r_bvalid <= 1'b1;
            r_bresp  <= is_mapped(r_aw_addr) ? OKAY : SLVERR;
         end else if (S_AXI_BREADY) r_bvalid <= 1'b0;
         // read samples registers before any same-edge commit lands
         if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rdata;
            r_rresp  <= is_mapped(5'(S_AXI_ARADDR)) ? OKAY : SLVERR;
         end else if (S_AXI_RREADY) r_rvalid <= 1'b0;
      end
   end
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_data_out   <= '0;
         r_dir        <= '0;
         r_irq_en     <= '0;
         r_scratch    <= '0;
         r_irq_status <= '0;
         r_irq        <= 1'b0;
      end else begin
         if (w_we_data) r_data_out <= merge(r_data_out);
         if (w_we_dir) r_dir <= merge(r_dir);
         if (w_we_en) r_irq_en <= merge(r_irq_en);
         if (w_we_scratch) r_scratch <= merge(r_scratch);
         // new edges override a same-cycle W1C clear
         r_irq_status <= (r_irq_status & ~w_clr) | (w_rise & r_irq_en);
         r_irq        <= |r_irq_status;
      end
   end
   assign S_AXI_AWREADY = r_awready;
   assign S_AXI_WREADY  = r_wready;
   assign S_AXI_ARREADY = r_arready;
   assign S_AXI_BVALID  = r_bvalid;
   assign S_AXI_BRESP   = r_bresp;
   assign S_AXI_RVALID  = r_rvalid;
   assign S_AXI_RRESP   = r_rresp;
   assign S_AXI_RDATA   = C_S_AXI_DATA_WIDTH'(r_rdata);
   assign gpio_o        = r_data_out;
   assign gpio_t        = ~r_dir;
   assign irq           = r_irq;
endmodule

// File: tb/tb_gpio_axi_lite_slave.sv
// tb_gpio_axi_lite_slave: directed scenarios plus randomized traffic checked against a
// register-map level reference model.
module tb_gpio_axi_lite_slave;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic [4:0]  awaddr = '0, araddr = '0;
   logic [2:0]  awprot = '0, arprot = '0;
   logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
   logic [31:0] wdata = '0, gpio_i = '0;
   logic [3:0]  wstrb = '0;
   logic        awready, wready, bvalid, arready, rvalid, irq;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata, gpio_o, gpio_t;
   int          n_total = 0, n_bad = 0;
   logic [31:0] m_reg [0:5];
   logic [1:0]  resp;
   always #5 clk = ~clk;
   gpio_axi_lite_slave dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
      .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_t(gpio_t), .irq(irq)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   // reference model: index 0..3 RW regs, 4 pin state, 5 IRQ_STATUS
   task automatic model_reset();
      for (int i = 0; i < 6; i++) m_reg[i] = '0;
      m_reg[4] = gpio_i;
   endtask
   task automatic model_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                              output logic [1:0] r);
      logic [31:0] m;
      int idx;
      for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{s[i]}};
      idx = int'(a[4:2]);
      if (idx < 4) m_reg[idx] = (m_reg[idx] & ~m) | (d & m);
      else if (idx == 5) m_reg[5] = m_reg[5] & ~(d & m);
      r = (idx > 5) ? 2'b10 : 2'b00;
   endtask
   task automatic model_pins(input logic [31:0] p);
      m_reg[5] = m_reg[5] | (p & ~m_reg[4] & m_reg[2]);
      m_reg[4] = p;
   endtask
   task automatic send_aw(input logic [4:0] a);
      int n = 0;
      awaddr = a; awvalid = 1;
      while (!awready && n < 100) begin @(posedge clk); #1; n++; end
      check("awready_wait", {31'd0, awready}, 1);
      @(posedge clk); #1 awvalid = 0;
   endtask
   task automatic send_w(input logic [31:0] d, input logic [3:0] s);
      int n = 0;
      wdata = d; wstrb = s; wvalid = 1;
      while (!wready && n < 100) begin @(posedge clk); #1; n++; end
      check("wready_wait", {31'd0, wready}, 1);
      @(posedge clk); #1 wvalid = 0;
   endtask
   task automatic wait_b(output logic [1:0] r);
      int n = 0;
      bready = 1;
      while (!bvalid && n < 100) begin @(posedge clk); #1; n++; end
      check("bvalid_wait", {31'd0, bvalid}, 1);
      r = bresp;
      @(posedge clk); #1 bready = 0;
   endtask
   task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int lead, output logic [1:0] r);
      fork
         begin
            if (lead < 0) begin repeat (-lead) @(posedge clk); #1; end
            send_aw(a);
         end
         begin
            if (lead > 0) begin repeat (lead) @(posedge clk); #1; end
            send_w(d, s);
         end
      join
      wait_b(r);
   endtask
   task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] r);
      int n = 0;
      araddr = a; arvalid = 1;
      while (!arready && n < 100) begin @(posedge clk); #1; n++; end
      check("arready_wait", {31'd0, arready}, 1);
      @(posedge clk); #1 arvalid = 0; rready = 1;
      n = 0;
      while (!rvalid && n < 100) begin @(posedge clk); #1; n++; end
      check("rvalid_wait", {31'd0, rvalid}, 1);
      d = rdata; r = rresp;
      @(posedge clk); #1 rready = 0;
   endtask
   task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s, input int lead);
      logic [1:0] got, exp;
      axi_write(a, d, s, lead, got);
      model_write(a, d, s, exp);
      check($sformatf("bresp@%h", a), {30'd0, got}, {30'd0, exp});
      check("gpio_o", gpio_o, m_reg[0]);
      check("gpio_t", gpio_t, ~m_reg[1]);
      check("irq_after_wr", {31'd0, irq}, {31'd0, m_reg[5] != 0});
   endtask
   task automatic do_read(input logic [4:0] a);
      logic [31:0] d, exp;
      logic [1:0] r;
      int idx;
      axi_read(a, d, r);
      idx = int'(a[4:2]);
      exp = (idx <= 5) ? m_reg[idx] : 32'd0;
      check($sformatf("rdata@%h", a), d, exp);
      check($sformatf("rresp@%h", a), {30'd0, r}, (idx <= 5) ? 32'd0 : 32'd2);
   endtask
   task automatic read_all();
      for (int i = 0; i < 8; i++) do_read(5'(i * 4));
   endtask
   initial begin
      int lead;
      logic [4:0] a;
      model_reset();
      #2;
      check("rst_awready", {31'd0, awready}, 0);
      check("rst_wready", {31'd0, wready}, 0);
      check("rst_arready", {31'd0, arready}, 0);
      check("rst_bvalid", {31'd0, bvalid}, 0);
      check("rst_rvalid", {31'd0, rvalid}, 0);
      check("rst_resp", {28'd0, bresp, rresp}, 0);
      check("rst_rdata", rdata, 0);
      check("rst_gpio_o", gpio_o, 0);
      check("rst_gpio_t", gpio_t, 32'hFFFF_FFFF);
      check("rst_irq", {31'd0, irq}, 0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1;
      @(posedge clk); #1;
      check("post_rst_ready", {29'd0, awready, wready, arready}, 3'b111);
      // basic write/readback
      for (int i = 0; i < 4; i++) do_write(5'(i * 4), 32'(i + 1), 4'hF, 0);
      for (int i = 0; i < 4; i++) do_read(5'(i * 4));
      check("t1_gpio_o", gpio_o, 32'd1);
      check("t1_gpio_t", gpio_t, ~32'd2);
      // W three cycles early, B backpressure, second write blocked
      wdata = 32'h1111_0000; wstrb = 4'hF; wvalid = 1;
      @(posedge clk); #1 wvalid = 0;
      check("t2_w_held", {31'd0, wready}, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("t2_no_b_yet", {31'd0, bvalid}, 0);
      awaddr = 5'h0C; awvalid = 1; bready = 0;
      @(posedge clk); #1 awvalid = 0;
      check("t2_b_latency0", {31'd0, bvalid}, 0);
      @(posedge clk); #1;
      check("t2_b_latency1", {31'd0, bvalid}, 1);
      model_write(5'h0C, 32'h1111_0000, 4'hF, resp);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check($sformatf("t2_b_hold%0d", i), {31'd0, bvalid}, 1);
      end
      awaddr = 5'h0C; awvalid = 1; wdata = 32'h2222_0000; wvalid = 1;
      @(posedge clk); #1 awvalid = 0; wvalid = 0;
      @(posedge clk); #1;
      check("t2_aw_blocked", {31'd0, awready}, 0);
      do_read(5'h0C);
      bready = 1;
      @(posedge clk); #1 bready = 0;
      check("t2_b_drop", {31'd0, bvalid}, 0);
      @(posedge clk); #1;
      check("t2_second_b", {31'd0, bvalid}, 1);
      model_write(5'h0C, 32'h2222_0000, 4'hF, resp);
      bready = 1;
      @(posedge clk); #1 bready = 0;
      do_read(5'h0C);
      // byte strobes
      do_write(5'h0C, 32'h0, 4'hF, 0);
      do_write(5'h0C, 32'hAABB_CCDD, 4'b0100, 0);
      do_read(5'h0C);
      check("t3_model", m_reg[3], 32'h00BB_0000);
      // interrupt path and latency
      do_write(5'h08, 32'h1, 4'hF, 0);
      gpio_i[0] = 1'b1;
      model_pins(gpio_i);
      repeat (3) @(posedge clk); #1;
      check("t4_irq_early", {31'd0, irq}, 0);
      @(posedge clk); #1;
      check("t4_irq_set", {31'd0, irq}, 1);
      do_read(5'h14);
      do_read(5'h10);
      gpio_i[0] = 1'b0;
      model_pins(gpio_i);
      repeat (5) @(posedge clk); #1;
      gpio_i[0] = 1'b1;
      @(posedge clk); #1;
      awaddr = 5'h14; awvalid = 1; wdata = 32'h1; wstrb = 4'hF; wvalid = 1;
      @(posedge clk); #1 awvalid = 0; wvalid = 0;
      wait_b(resp);
      check("t4_clr_bresp", {30'd0, resp}, 0);
      model_write(5'h14, 32'h1, 4'hF, resp);
      model_pins(gpio_i);
      do_read(5'h14);
      check("t4_set_wins", m_reg[5], 32'h1);
      check("t4_irq_kept", {31'd0, irq}, 1);
      do_write(5'h14, 32'h1, 4'hF, 0);
      do_read(5'h14);
      check("t4_irq_clr", {31'd0, irq}, 0);
      // unmapped
      do_read(5'h18);
      do_write(5'h1C, 32'hFFFF_FFFF, 4'hF, 0);
      do_write(5'h10, 32'hFFFF_FFFF, 4'hF, 0);
      read_all();
      // randomized traffic
      for (int it = 0; it < 150; it++) begin
         a = 5'($urandom_range(31));
         case ($urandom_range(3))
            0, 1: begin
               lead = int'($urandom_range(6)) - 3;
               do_write(a, $urandom, 4'($urandom_range(15)), lead);
            end
            2: do_read(a);
            default: begin
               gpio_i = $urandom;
               model_pins(gpio_i);
               repeat (5) @(posedge clk); #1;
               check("rnd_irq", {31'd0, irq}, {31'd0, m_reg[5] != 0});
            end
         endcase
      end
      read_all();
      // reset in the middle of outstanding B and R
      do_write(5'h00, 32'h5A, 4'hF, 0);
      awaddr = 5'h0C; awvalid = 1; wdata = 32'h77; wstrb = 4'hF; wvalid = 1;
      araddr = 5'h00; arvalid = 1; bready = 0; rready = 0;
      @(posedge clk); #1 awvalid = 0; wvalid = 0; arvalid = 0;
      @(posedge clk); #1;
      check("t6_bvalid_pre", {31'd0, bvalid}, 1);
      check("t6_rvalid_pre", {31'd0, rvalid}, 1);
      check("t6_rdata_pre", rdata, 32'h5A);
      rst_n = 0;
      #1;
      check("t6_bvalid_rst", {31'd0, bvalid}, 0);
      check("t6_rvalid_rst", {31'd0, rvalid}, 0);
      check("t6_gpio_o_rst", gpio_o, 0);
      check("t6_gpio_t_rst", gpio_t, 32'hFFFF_FFFF);
      check("t6_ready_rst", {29'd0, awready, wready, arready}, 0);
      model_reset();
      @(posedge clk); #3 rst_n = 1;
      @(posedge clk); #1;
      check("t6_ready_back", {29'd0, awready, wready, arready}, 3'b111);
      read_all();
      do_write(5'h04, 32'hF0F0_F0F0, 4'hF, 1);
      do_read(5'h04);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
endmodule
